// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The bit timer in this package's companion module is also meant for the RX side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int FRAME_W              = 11;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [3:0] SEL_START      = 4'd0;
  localparam logic [3:0] SEL_FIRST_DATA = 4'd1;
  localparam logic [3:0] SEL_LAST_DATA  = 4'd8;
  localparam logic [3:0] SEL_PARITY     = 4'd9;
  localparam logic [3:0] SEL_STOP       = 4'd10;

  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h400;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic calc_parity(input logic [7:0] data, input logic en, input logic odd);
    return en ? ((^data) ^ odd) : 1'b0;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear and terminal-count strobe.
// tc is high during the last cycle of each CLKS_PER_BIT-long bit period.
module uart_bit_timer
  #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
  );

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc_s;

  // Terminal-count detect and next count value.
  always_comb begin
    cnt_d = cnt_q;
    tc_s  = en && (cnt_q == CNT_LAST);
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tc_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = tc_s;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: latches a byte into an 11-bit frame and steps the
// downstream mux select through it, holding each bit for CLKS_PER_BIT cycles.
module uart_tx_ctrl
  import uart_pkg::*;
  #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
  )
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    input  logic               parity_en,
    input  logic               parity_odd,
    output logic               tx_ready,
    output logic [FRAME_W-1:0] frame,
    output logic [3:0]         sel,
    output logic               busy,
    output logic               tx_done
  );

  tx_state_e          state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;
  logic               par_en_q, par_en_d;
  logic               accept_s;
  logic               bit_end_s;

  assign accept_s = tx_valid && tx_ready_q && (state_q == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_s),
    .en    (busy_q),
    .tc    (bit_end_s)
  );

  // Next-state, select and frame logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    frame_d    = frame_q;
    tx_ready_d = tx_ready_q;
    par_en_d   = par_en_q;
    tx_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          frame_d    = {1'b1, calc_parity(tx_data, parity_en, parity_odd), tx_data, 1'b0};
          par_en_d   = parity_en;
          sel_d      = SEL_START;
          tx_ready_d = 1'b0;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          sel_d   = SEL_FIRST_DATA;
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (!bit_end_s) begin
          state_d = ST_DATA;
        end else if (sel_q < SEL_LAST_DATA) begin
          sel_d = sel_q + 4'd1;
        end else if (par_en_q) begin
          sel_d   = SEL_PARITY;
          state_d = ST_PARITY;
        end else begin
          sel_d   = SEL_STOP;
          state_d = ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          sel_d   = SEL_STOP;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          tx_ready_d = 1'b1;
          tx_done_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        // Unreachable encoding: park on the stop bit so the line stays high.
        state_d    = ST_IDLE;
        sel_d      = SEL_STOP;
        frame_d    = IDLE_FRAME;
        tx_ready_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_STOP;
      frame_q    <= IDLE_FRAME;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      par_en_q   <= par_en_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign frame    = frame_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule
